// File: rtl/regression_result_unloader.sv
// Output end of the regression datapath: buffers the error stream, latches the coefficients
// and replays b_0, b_1 and the errors to a valid/ready consumer while summing |error|.
module regression_result_unloader #(
   parameter int unsigned DATA_WIDTH = 20,
   parameter int unsigned N_SAMPLES  = 150,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned SUM_WIDTH  = DATA_WIDTH + ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  coef_valid,
   input  logic [DATA_WIDTH-1:0] b_0,
   input  logic [DATA_WIDTH-1:0] b_1,
   input  logic                  error_valid,
   input  logic [DATA_WIDTH-1:0] error,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic [SUM_WIDTH-1:0]  error_sum,
   output logic                  done,
   output logic                  overflow
);

   typedef enum logic [2:0] {
      StIdle, StCollect, StWaitCoef, StSendB0, StSendB1, StSendErr, StDone
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(N_SAMPLES - 1);
   localparam logic [ADDR_WIDTH-1:0] OneIdx  = ADDR_WIDTH'(1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
   logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
   logic [DATA_WIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
   logic                  coef_seen_q, coef_seen_d;
   logic [SUM_WIDTH-1:0]  sum_q, sum_d;
   logic                  ovf_q, ovf_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] abs_err;
   logic                  xfer;

   logic [DATA_WIDTH-1:0] err_mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (mem_we) err_mem[wr_idx_q] <= error;
   end

   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      coef_seen_d = coef_seen_q;
      sum_d       = sum_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      mem_we      = 1'b0;
      // 0x80000 negates to itself, which read unsigned is exactly 2^19
      abs_err     = error[DATA_WIDTH-1] ? -error : error;
      xfer        = out_valid_q && out_ready;

      if (error_valid && state_q != StCollect) ovf_d = 1'b1;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d     = StCollect;
               wr_idx_d    = '0;
               rd_idx_d    = '0;
               sum_d       = '0;
               coef_seen_d = 1'b0;
               ovf_d       = 1'b0;
            end
         end
         StCollect: begin
            if (coef_valid) begin
               b0_d        = b_0;
               b1_d        = b_1;
               coef_seen_d = 1'b1;
            end
            if (error_valid) begin
               mem_we   = 1'b1;
               wr_idx_d = wr_idx_q + OneIdx;
               sum_d    = sum_q + SUM_WIDTH'(abs_err);
               if (wr_idx_q == LastIdx) begin
                  state_d = (coef_seen_q || coef_valid) ? StSendB0 : StWaitCoef;
               end
            end
         end
         StWaitCoef: begin
            if (coef_valid) begin
               b0_d        = b_0;
               b1_d        = b_1;
               coef_seen_d = 1'b1;
               state_d     = StSendB0;
            end
         end
         StSendB0: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = b0_q;
            end else if (out_ready) begin
               out_data_d = b1_q;
               state_d    = StSendB1;
            end
         end
         StSendB1: begin
            if (xfer) begin
               out_data_d = err_mem[0];
               rd_idx_d   = OneIdx;
               out_last_d = (LastIdx == '0);
               state_d    = StSendErr;
            end
         end
         StSendErr: begin
            if (xfer) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = StDone;
               end else begin
                  // prefetch: the word at rd_idx becomes visible at this edge
                  out_data_d = err_mem[rd_idx_q];
                  rd_idx_d   = rd_idx_q + OneIdx;
                  out_last_d = (rd_idx_q == LastIdx);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         wr_idx_q    <= '0;
         rd_idx_q    <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         coef_seen_q <= 1'b0;
         sum_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         coef_seen_q <= coef_seen_d;
         sum_q       <= sum_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign error_sum = sum_q;
   assign overflow  = ovf_q;
   assign done      = (state_q == StDone);

endmodule
